// File: rtl/or_sched_pkg.sv
// Shared types and constants for the OR-unit scheduler.
package or_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DW           = 16;
  localparam int NREQ_DEFAULT = 4;

endpackage

// File: rtl/or_unit_scheduler_if.sv
// Requester and response bundle between the requesting units and the scheduler.
interface or_sched_if
  import or_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT,
  parameter int IDW  = $clog2(NREQ)
) ();

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_a;
  logic [NREQ*DW-1:0] req_b;
  logic [NREQ-1:0]    req_ready;
  logic               resp_valid;
  logic [IDW-1:0]     resp_id;
  logic [DW-1:0]      resp_data;
  logic               resp_ready;
  logic               busy;

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_data, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_id, resp_data, busy
  );

endinterface

// File: rtl/or_unit_scheduler_rr_picker.sv
// Round-robin picker: first requester found searching from last+1, wrapping.
module rr_picker #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx
);

  int  cand;
  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(last) + k) % NREQ;
      if (!found && req[IDW'(cand)]) begin
        found              = 1'b1;
        grant[IDW'(cand)]  = 1'b1;
        idx                = IDW'(cand);
      end
    end
  end

endmodule

// File: rtl/sixteen_bit_or.sv
// Shared bitwise-OR datapath, one lane per bit.
module sixteen_bit_or
  import or_sched_pkg::*;
(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] y
);

  for (genvar gi = 0; gi < DW; gi++) begin : g_lane
    assign y[gi] = a[gi] | b[gi];
  end

endmodule

// File: rtl/or_unit_scheduler.sv
// Time-shares one sixteen_bit_or among NREQ requesters with a tagged response port.
// Define OR_SCHED_RR_EN for round-robin arbitration; otherwise lowest index wins.
module or_unit_scheduler
  import or_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT,
  parameter int IDW  = $clog2(NREQ)
) (
  input logic     clk,
  input logic     rst,
  or_sched_if.slave bus
);

  state_t          state_reg, state_next;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_idx;
  logic [IDW-1:0]  last_sel;
  logic            take;
  logic [DW-1:0]   a_reg, b_reg, data_reg, or_y;
  logic [IDW-1:0]  id_reg;
  logic [DW-1:0]   a_arr [NREQ];
  logic [DW-1:0]   b_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign a_arr[gi] = bus.req_a[DW*gi +: DW];
    assign b_arr[gi] = bus.req_b[DW*gi +: DW];
  end

`ifdef OR_SCHED_RR_EN
  logic [IDW-1:0] last_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_reg <= IDW'(NREQ - 1);
    end else if (take) begin
      last_reg <= grant_idx;
    end
  end

  assign last_sel = last_reg;
`else
  // Pinning the search start to NREQ-1 turns the picker into lowest-index-first.
  assign last_sel = IDW'(NREQ - 1);
`endif

  rr_picker #(.NREQ(NREQ), .IDW(IDW)) u_picker (
    .req   (bus.req_valid),
    .last  (last_sel),
    .grant (grant),
    .idx   (grant_idx)
  );

  always_comb begin
    state_next = state_reg;
    take       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!rst && (|bus.req_valid)) begin
          take       = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC:    state_next = RESP;
      RESP:    if (bus.resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      id_reg    <= '0;
      data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (take) begin
        a_reg  <= a_arr[grant_idx];
        b_reg  <= b_arr[grant_idx];
        id_reg <= grant_idx;
      end
      if (state_reg == EXEC) begin
        data_reg <= or_y;
      end
    end
  end

  // The datapath only ever sees the latched operands, never the live request bus.
  sixteen_bit_or u_or (
    .a (a_reg),
    .b (b_reg),
    .y (or_y)
  );

  assign bus.req_ready  = take ? grant : '0;
  assign bus.resp_valid = (state_reg == RESP);
  assign bus.resp_id    = id_reg;
  assign bus.resp_data  = data_reg;
  assign bus.busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_or_unit_scheduler.sv
// Self-checking bench: vector table, hand-written corner sequences, random traffic vs model.
module tb_or_unit_scheduler;
  import or_sched_pkg::*;

  localparam int NREQ = 4;
  localparam int IDW  = $clog2(NREQ);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  or_sched_if #(.NREQ(NREQ)) bus ();

  or_unit_scheduler #(.NREQ(NREQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          id;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] y;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Arbitration rule from the block description, independent of the RTL picker.
  function automatic int pick(input logic [NREQ-1:0] v, input int last);
`ifdef OR_SCHED_RR_EN
    for (int k = 1; k <= NREQ; k++)
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
`else
    for (int i = 0; i < NREQ; i++)
      if (v[i]) return i;
`endif
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    bus.resp_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic single(input int id, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] y);
    bus.req_valid = '0;
    bus.req_valid[id] = 1'b1;
    bus.req_a[16*id +: 16] = a;
    bus.req_b[16*id +: 16] = b;
    bus.resp_ready = 1'b1;
    #1;
    chk("single_grant", 32'(bus.req_ready), 32'(1 << id));
    tick();
    bus.req_valid = '0;
    #1;
    chk("exec_resp_valid", 32'(bus.resp_valid), 0);
    chk("exec_busy", 32'(bus.busy), 1);
    tick();
    #1;
    chk("resp_valid", 32'(bus.resp_valid), 1);
    chk("resp_id", 32'(bus.resp_id), 32'(id));
    chk("resp_data", 32'(bus.resp_data), 32'(y));
    $display("txn id=%0d a=%h b=%h data=%h", id, a, b, bus.resp_data);
    tick();
    #1;
    chk("idle_busy", 32'(bus.busy), 0);
  endtask

  // Drive a granted transaction (already in EXEC after the next edge) to completion.
  task automatic finish_txn();
    tick();
    bus.req_valid = '0;
    bus.resp_ready = 1'b1;
    tick();
    tick();
  endtask

  vec_t vecs[6];
  logic [NREQ-1:0] pend;
  logic [15:0] pa[NREQ];
  logic [15:0] pb[NREQ];

  initial begin
    int prev, w, g, exp_g, m_last, m_id, m_gc, hs_count;
    bit m_out, exp_rv;
    logic [15:0] m_data, bp_data;

    vecs[0] = '{0, 16'h00F0, 16'h0F01, 16'h0FF1};
    vecs[1] = '{0, 16'h0000, 16'h0000, 16'h0000};
    vecs[2] = '{1, 16'hFFFF, 16'h0000, 16'hFFFF};
    vecs[3] = '{2, 16'hAAAA, 16'h5555, 16'hFFFF};
    vecs[4] = '{3, 16'h1234, 16'h4321, 16'h5335};
    vecs[5] = '{0, 16'h8000, 16'h0001, 16'h8001};

    bus.req_a = '0;
    bus.req_b = '0;
    do_reset();
    rst = 1'b1;
    #1;
    chk("rst_resp_valid", 32'(bus.resp_valid), 0);
    chk("rst_resp_id", 32'(bus.resp_id), 0);
    chk("rst_resp_data", 32'(bus.resp_data), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) single(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].y);

    // Contention with all four requesting continuously.
    do_reset();
    bus.req_valid = '1;
    bus.resp_ready = 1'b1;
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      w = 0;
      #1;
      while (bus.req_ready == '0 && w < 10) begin
        tick();
        #1;
        w++;
      end
      chk("contention_grant_seen", 32'(bus.req_ready != '0), 1);
`ifdef OR_SCHED_RR_EN
      exp_g = k % NREQ;
`else
      exp_g = 0;
`endif
      chk("contention_grant", 32'(bus.req_ready), 32'(1 << exp_g));
      if (k > 0) chk("contention_spacing", 32'(cyc - prev), 3);
      $display("grant %0d -> req_ready=%b at cycle %0d", k, bus.req_ready, cyc);
      prev = cyc;
      tick();
    end
    bus.req_valid = '0;
    tick();
    tick();

    // Backpressure: response held for 5 cycles, no grants meanwhile.
    do_reset();
    bus.req_valid = 4'b0001;
    bus.req_a[15:0] = 16'h1357;
    bus.req_b[15:0] = 16'h2468;
    bus.resp_ready = 1'b0;
    #1;
    chk("bp_grant", 32'(bus.req_ready), 1);
    tick();
    bus.req_valid = '1;
    tick();
    #1;
    chk("bp_resp_valid", 32'(bus.resp_valid), 1);
    bp_data = bus.resp_data;
    chk("bp_resp_data", 32'(bp_data), 32'h377F);
    for (int k = 0; k < 5; k++) begin
      tick();
      #1;
      chk("bp_hold_valid", 32'(bus.resp_valid), 1);
      chk("bp_hold_id", 32'(bus.resp_id), 0);
      chk("bp_hold_data", 32'(bus.resp_data), 32'h377F);
      chk("bp_no_grant", 32'(bus.req_ready), 0);
    end
    bus.resp_ready = 1'b1;
    #1;
    chk("bp_no_comb_path", 32'(bus.req_ready), 0);
    tick();
    #1;
    chk("bp_resume_grant", 32'(bus.req_ready), 32'(1 << pick(4'b1111, 0)));
    $display("backpressure released, req_ready=%b", bus.req_ready);
    finish_txn();

    // Wrap-around of the search pointer.
    do_reset();
    single(3, 16'h0101, 16'h1010, 16'h1111);
    bus.req_valid = 4'b0110;
    #1;
    chk("wrap_grant_1", 32'(bus.req_ready), 32'b0010);
    finish_txn();
    bus.req_valid = 4'b0011;
    #1;
    chk("wrap_grant_0", 32'(bus.req_ready), 32'b0001);
    $display("wrap grant req_ready=%b", bus.req_ready);
    finish_txn();

    // Reset during EXEC discards the transaction.
    do_reset();
    single(3, 16'h0F0F, 16'h0000, 16'h0F0F);
    bus.req_valid = 4'b0100;
    #1;
    chk("midrst_grant", 32'(bus.req_ready), 32'b0100);
    tick();
    rst = 1'b1;
    bus.req_valid = '0;
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_resp_valid", 32'(bus.resp_valid), 0);
    chk("midrst_busy", 32'(bus.busy), 0);
    bus.req_valid = '1;
    #1;
    chk("midrst_first_grant", 32'(bus.req_ready), 32'b0001);
    $display("after mid-op reset req_ready=%b", bus.req_ready);
    finish_txn();

    // Random traffic against a transaction-level model.
    do_reset();
    pend = '0;
    m_last = NREQ - 1;
    m_out = 1'b0;
    m_id = 0;
    m_gc = 0;
    m_data = '0;
    hs_count = 0;
    for (int t = 0; t < 600; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          pa[i] = 16'($urandom);
          pb[i] = 16'($urandom);
        end else if (pend[i] && $urandom_range(0, 19) == 0) begin
          pend[i] = 1'b0;
        end
        bus.req_a[16*i +: 16] = pa[i];
        bus.req_b[16*i +: 16] = pb[i];
      end
      bus.req_valid = pend;
      bus.resp_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_rv = m_out && (t >= m_gc + 2);
      g = (!m_out && pend != '0) ? pick(pend, m_last) : -1;
      chk("rnd_req_ready", 32'(bus.req_ready), (g >= 0) ? 32'(1 << g) : 0);
      chk("rnd_resp_valid", 32'(bus.resp_valid), 32'(exp_rv));
      chk("rnd_busy", 32'(bus.busy), 32'(m_out));
      if (exp_rv) begin
        chk("rnd_resp_id", 32'(bus.resp_id), 32'(m_id));
        chk("rnd_resp_data", 32'(bus.resp_data), 32'(m_data));
        if (bus.resp_ready) begin
          $display("rnd txn id=%0d data=%h", m_id, m_data);
          m_out = 1'b0;
          hs_count++;
        end
      end
      if (g >= 0) begin
        m_out = 1'b1;
        m_id = g;
        m_data = pa[g] | pb[g];
        m_gc = t;
        m_last = g;
        pend[g] = 1'b0;
      end
      tick();
    end
    chk("rnd_traffic_flowed", 32'(hs_count > 20), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/or_unit_scheduler.md
# or_unit_scheduler

Shares a single 16-bit bitwise-OR datapath among NREQ requesters. Each requester presents two operands on a valid/ready handshake. The block grants one requester at a time, latches its operands, computes the OR through the shared `sixteen_bit_or` instance, and returns the tagged result on a single valid/ready response port. It sits between the requesting units and the OR datapath and is the only driver of that datapath's inputs.

## Interface
- `NREQ`, default 4: number of requesters; legal range 2..8.
- `IDW`, default `$clog2(NREQ)`: width of the requester index (derived; do not override).
- `clk` input, 1 bit: single clock; all state changes on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `req_valid` input, NREQ bits: bit i asserted means requester i has operands pending.
- `req_a` input, NREQ*16 bits: operand A; requester i occupies bits `[16*i+15:16*i]`.
- `req_b` input, NREQ*16 bits: operand B; same packing as `req_a`.
- `req_ready` output, NREQ bits: one-hot grant; bit i asserted means requester i's operands are accepted this cycle.
- `resp_valid` output, 1 bit: result available.
- `resp_id` output, IDW bits: index of the requester that owns the result.
- `resp_data` output, 16 bits: `a | b` for the granted request.
- `resp_ready` input, 1 bit: consumer accepts the response.
- `busy` output, 1 bit: high whenever the FSM is not in IDLE.

## Operation
- FSM states:
  - IDLE: no transaction in flight.
  - EXEC: latched operands are driven into `sixteen_bit_or`; the result is captured into `resp_data`.
  - RESP: the result is held on the response port.
- IDLE → EXEC when any `req_valid` bit is set. In that cycle, `req_ready[g]` = 1 for the selected requester g. The block latches `req_a[g]`, `req_b[g]` and g.
- EXEC → RESP unconditionally after 1 cycle.
- RESP → IDLE when `resp_valid && resp_ready`. `resp_valid`, `resp_id` and `resp_data` stay stable until that handshake.
- `req_ready` is combinational from `req_valid` and the pointer. It is nonzero only in IDLE and is always one-hot or zero. It never depends on `req_a` or `req_b`.
- A requester must hold `req_valid` and its operands stable until its `req_ready` bit is seen. Dropping `req_valid` before grant is permitted and withdraws the request.
- Arbitration is round-robin (see Configuration). `last` holds the index of the most recent grant. The search starts at `last+1` and wraps modulo NREQ. `last` updates only on a grant.
- Only one transaction is in flight; there is no queuing. Requests arriving in EXEC or RESP wait.
- Reset values: FSM = IDLE; `req_ready` = 0; `resp_valid` = 0; `resp_id` = 0; `resp_data` = 0; `busy` = 0; `last` = NREQ-1, so requester 0 wins first.
- Reset mid-operation: the in-flight transaction is discarded without a response. `resp_valid` is 0 in the cycle after `rst` is sampled high.

## Timing
- Grant at cycle N → EXEC at N+1 → `resp_valid` = 1 at N+2. Minimum latency from grant to result is 2 cycles.
- If `resp_ready` = 1 at N+2, the FSM is back in IDLE at N+3 and the next grant can occur at N+3.
- Peak throughput is one result per 3 cycles.
- Response backpressure: RESP holds indefinitely. No new grant occurs while `resp_valid` = 1.
- No combinational path from `resp_ready` to `req_ready`.

## Configuration
- `OR_SCHED_RR_EN` defined: round-robin arbitration as described above, including the `last` register.
- `OR_SCHED_RR_EN` undefined: fixed priority, lowest index wins. The `last` register is not built; all other behaviour is identical.

## Structure
- Package `or_sched_pkg` holds:
  - the state typedef (`IDLE`, `EXEC`, `RESP`);
  - the datapath width constant (16);
  - the default NREQ constant.
- Sub-module `rr_picker` (NREQ): inputs are the request vector and `last`; outputs are the one-hot grant and the encoded index. The fixed-priority variant is the same module with `last` tied to NREQ-1.
- One `sixteen_bit_or` instance, fed only from the latched operand registers.

## Test plan
- Single request: after reset, `req_valid` = 0001, a = 0x00F0, b = 0x0F01 → `req_ready` = 0001 in the same cycle; `resp_valid` 2 cycles later with `resp_id` = 0, `resp_data` = 0x0FF1.
- Contention, RR build: `req_valid` = 1111 held with `resp_ready` = 1 → grant order 0,1,2,3,0, with a grant every 3 cycles. Fixed-priority build → requester 0 granted every time.
- Backpressure: `resp_ready` = 0 for 5 cycles after `resp_valid` rises → `resp_valid`, `resp_id`, `resp_data` stable; `req_ready` stays 0 throughout; grant resumes the cycle after the handshake.
- Wrap-around: `last` = 3, `req_valid` = 0110 → requester 1 granted. Next grant with `req_valid` = 0011 → requester 0 granted (RR build).
- Reset mid-operation: assert `rst` during EXEC → next cycle `resp_valid` = 0, `busy` = 0; the following request from requester 0 is granted first.
- Extremes: a = 0x0000, b = 0x0000 → 0x0000; a = 0xFFFF, b = 0x0000 → 0xFFFF; a = 0xAAAA, b = 0x5555 → 0xFFFF.
